// File: rtl/axi_gmem_slave_mem_if.sv
// axi_gmem_slave_mem_if: AXI4 gmem bus between a kernel master and the memory responder
interface axi_gmem_slave_mem_if #(
    parameter int C_ID_WIDTH   = 1,
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 32
);
    logic                      AWVALID, AWREADY;
    logic [C_ADDR_WIDTH-1:0]   AWADDR;
    logic [C_ID_WIDTH-1:0]     AWID;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      WVALID, WREADY, WLAST;
    logic [C_DATA_WIDTH-1:0]   WDATA;
    logic [C_DATA_WIDTH/8-1:0] WSTRB;
    logic                      BVALID, BREADY;
    logic [C_ID_WIDTH-1:0]     BID;
    logic [1:0]                BRESP;
    logic                      ARVALID, ARREADY;
    logic [C_ADDR_WIDTH-1:0]   ARADDR;
    logic [C_ID_WIDTH-1:0]     ARID;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      RVALID, RREADY, RLAST;
    logic [C_DATA_WIDTH-1:0]   RDATA;
    logic [C_ID_WIDTH-1:0]     RID;
    logic [1:0]                RRESP;

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP,
        output ARREADY, RVALID, RDATA, RID, RRESP, RLAST
    );

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST, BREADY,
        output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP,
        input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST
    );
endinterface

// File: rtl/axi_gmem_slave_mem.sv
// axi_gmem_slave_mem: AXI4 INCR-burst memory responder with independent read and write channels
module axi_gmem_slave_mem #(
    parameter int C_ID_WIDTH   = 1,
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DEPTH      = 1024,
    parameter int C_R_GAP      = 0
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    axi_gmem_slave_mem_if.slave s_axi
);
    localparam int NB    = C_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int IW    = $clog2(C_DEPTH);
    localparam int GW    = 4;
    localparam logic [2:0] SIZE   = 3'(SHIFT);
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [C_ADDR_WIDTH-1:0] DEPTH_W = C_ADDR_WIDTH'(C_DEPTH);
    localparam logic [C_ADDR_WIDTH-1:0] ONE     = C_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} r_state_t;

    logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];

    w_state_t                w_state;
    logic [C_ADDR_WIDTH-1:0] w_idx;
    logic [7:0]              w_len, w_cnt;
    logic                    w_bad, w_err;
    logic                    aw_fire, w_fire, w_oob, w_we, w_full, w_end;

    r_state_t                r_state;
    logic [C_ADDR_WIDTH-1:0] r_idx, r_src, ar_idx;
    logic [7:0]              r_cnt;
    logic                    r_bad, ar_bad, ar_fire, r_src_err;
    logic [GW-1:0]           r_gap;
    logic [C_DATA_WIDTH-1:0] r_src_data;

    // Write-side handshake decode; a burst with bad type/size consumes beats but never touches the array
    always_comb begin
        aw_fire = w_state == W_IDLE && s_axi.AWREADY && s_axi.AWVALID;
        w_fire  = w_state == W_DATA && s_axi.WREADY && s_axi.WVALID;
        w_oob   = w_idx >= DEPTH_W;
        w_we    = w_fire && !w_bad && !w_oob;
        w_full  = w_cnt == w_len;
        w_end   = s_axi.WLAST || w_full;
    end

    // Read-side beat source: the AR address on acceptance, the already-advanced index after a gap, else the next word
    always_comb begin
        ar_fire    = r_state == R_IDLE && s_axi.ARREADY && s_axi.ARVALID;
        ar_idx     = s_axi.ARADDR >> SHIFT;
        ar_bad     = s_axi.ARBURST != INCR || s_axi.ARSIZE != SIZE;
        r_src      = ar_fire ? ar_idx : (r_state == R_GAP ? r_idx : r_idx + ONE);
        r_src_err  = (ar_fire ? ar_bad : r_bad) || r_src >= DEPTH_W;
        r_src_data = r_src_err ? '0 : mem[r_src[IW-1:0]];
    end

    // Array update by byte lane; contents survive reset, and a write coinciding with reset is dropped
    always_ff @(posedge ap_clk) begin
        if (w_we && !ap_rst)
            for (int b = 0; b < NB; b++)
                if (s_axi.WSTRB[b]) mem[w_idx[IW-1:0]][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
    end

    // Write channel: accept AW, count W beats until WLAST or len+1, then hold B until taken
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            w_state       <= W_IDLE;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b0;
            s_axi.BVALID  <= 1'b0;
            s_axi.BID     <= '0;
            s_axi.BRESP   <= OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_bad         <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        s_axi.AWREADY <= 1'b0;
                        s_axi.WREADY  <= 1'b1;
                        s_axi.BID     <= s_axi.AWID;
                        w_idx         <= s_axi.AWADDR >> SHIFT;
                        w_len         <= s_axi.AWLEN;
                        w_cnt         <= '0;
                        w_bad         <= s_axi.AWBURST != INCR || s_axi.AWSIZE != SIZE;
                        w_err         <= 1'b0;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi.AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + ONE;
                        w_cnt <= w_cnt + 8'd1;
                        w_err <= w_err || w_oob;
                        if (w_end) begin
                            s_axi.WREADY <= 1'b0;
                            s_axi.BVALID <= 1'b1;
                            s_axi.BRESP  <= (w_err || w_oob || w_bad || s_axi.WLAST != w_full) ? SLVERR : OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        s_axi.BVALID  <= 1'b0;
                        s_axi.AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel: accept AR, present registered beats held through stalls, optional idle gap between beats
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state       <= R_IDLE;
            s_axi.ARREADY <= 1'b0;
            s_axi.RVALID  <= 1'b0;
            s_axi.RLAST   <= 1'b0;
            s_axi.RDATA   <= '0;
            s_axi.RRESP   <= OKAY;
            s_axi.RID     <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_bad         <= 1'b0;
            r_gap         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_axi.ARREADY <= 1'b0;
                        s_axi.RVALID  <= 1'b1;
                        s_axi.RDATA   <= r_src_data;
                        s_axi.RRESP   <= r_src_err ? SLVERR : OKAY;
                        s_axi.RLAST   <= s_axi.ARLEN == 8'd0;
                        s_axi.RID     <= s_axi.ARID;
                        r_idx         <= ar_idx;
                        r_cnt         <= s_axi.ARLEN;
                        r_bad         <= ar_bad;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi.ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.RREADY) begin
                        if (s_axi.RLAST) begin
                            s_axi.RVALID  <= 1'b0;
                            s_axi.ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_idx       <= r_idx + ONE;
                            r_cnt       <= r_cnt - 8'd1;
                            s_axi.RLAST <= r_cnt == 8'd1;
                            if (C_R_GAP > 0) begin
                                s_axi.RVALID <= 1'b0;
                                r_gap        <= GW'(C_R_GAP - 1);
                                r_state      <= R_GAP;
                            end else begin
                                s_axi.RDATA <= r_src_data;
                                s_axi.RRESP <= r_src_err ? SLVERR : OKAY;
                            end
                        end
                    end
                end
                R_GAP: begin
                    if (r_gap == '0) begin
                        s_axi.RVALID <= 1'b1;
                        s_axi.RDATA  <= r_src_data;
                        s_axi.RRESP  <= r_src_err ? SLVERR : OKAY;
                        r_state      <= R_DATA;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
